// File: rtl/pipe_stage_reg_if.sv
// Signal bundle for one Y86 pipeline stage boundary: upstream fields and
// control in, registered fields, status flags and perf counters out.
interface pipe_stage_reg_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_VAL = 4,
    parameter int NUM_DST = 2,
    parameter int CNT_W   = 32
);
    logic                      stall_i;
    logic                      bubble_i;
    logic [3:0]                icode_i;
    logic [3:0]                ifun_i;
    logic [2:0]                stat_i;
    logic [NUM_VAL*DATA_W-1:0] vals_i;
    logic [NUM_DST*4-1:0]      dsts_i;

    logic [3:0]                icode_o;
    logic [3:0]                ifun_o;
    logic [2:0]                stat_o;
    logic [NUM_VAL*DATA_W-1:0] vals_o;
    logic [NUM_DST*4-1:0]      dsts_o;
    logic                      valid_o;
    logic                      conflict_o;
    logic [CNT_W-1:0]          bubble_cnt_o;
    logic [CNT_W-1:0]          stall_cnt_o;

    modport master (
        output stall_i, bubble_i, icode_i, ifun_i, stat_i, vals_i, dsts_i,
        input  icode_o, ifun_o, stat_o, vals_o, dsts_o, valid_o, conflict_o,
               bubble_cnt_o, stall_cnt_o
    );

    modport slave (
        input  stall_i, bubble_i, icode_i, ifun_i, stat_i, vals_i, dsts_i,
        output icode_o, ifun_o, stat_o, vals_o, dsts_o, valid_o, conflict_o,
               bubble_cnt_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised Y86 pipeline stage register with load/stall/bubble, valid and
// sticky conflict flag. Define PIPE_PERF_CNT_EN to build the saturating perf counters.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int NUM_VAL = 4,
    parameter int NUM_DST = 2,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_reg_if.slave      stg
);
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [2:0] AOK   = 3'h1;
    localparam logic [3:0] RNONE = 4'hF;

    generate
        if (NUM_VAL < 1 || NUM_VAL > 4) begin : g_bad_num_val
            $fatal(1, "pipe_stage_reg: NUM_VAL must be in 1..4");
        end
        if (NUM_DST < 1 || NUM_DST > 2) begin : g_bad_num_dst
            $fatal(1, "pipe_stage_reg: NUM_DST must be in 1..2");
        end
    endgenerate

    logic                      w_load;
    logic [NUM_VAL*DATA_W-1:0] w_vals;
    logic [NUM_DST*4-1:0]      w_dsts;
    logic [3:0]                r_icode;
    logic [3:0]                r_ifun;
    logic [2:0]                r_stat;
    logic                      r_valid;
    logic                      r_conflict;

    assign w_load = ~stg.bubble_i & ~stg.stall_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_icode <= INOP;
            r_ifun  <= 4'h0;
            r_stat  <= AOK;
            r_valid <= 1'b0;
        end else if (stg.bubble_i) begin
            r_icode <= INOP;
            r_ifun  <= 4'h0;
            r_stat  <= AOK;
            r_valid <= 1'b0;
        end else if (!stg.stall_i) begin
            r_icode <= stg.icode_i;
            r_ifun  <= stg.ifun_i;
            r_stat  <= stg.stat_i;
            r_valid <= (stg.icode_i != INOP);
        end
    end

    // Sticky: once control has asked for stall and bubble together, keep flagging it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_conflict <= 1'b0;
        end else if (stg.stall_i && stg.bubble_i) begin
            r_conflict <= 1'b1;
        end
    end

    genvar gi;
    generate
        // Values are left untouched by a bubble; only a real load changes them.
        for (gi = 0; gi < NUM_VAL; gi++) begin : g_val
            logic [DATA_W-1:0] r_val;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_val <= '0;
                end else if (w_load) begin
                    r_val <= stg.vals_i[gi*DATA_W +: DATA_W];
                end
            end
            assign w_vals[gi*DATA_W +: DATA_W] = r_val;
        end

        for (gi = 0; gi < NUM_DST; gi++) begin : g_dst
            logic [3:0] r_dst;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_dst <= RNONE;
                end else if (stg.bubble_i) begin
                    r_dst <= RNONE;
                end else if (!stg.stall_i) begin
                    r_dst <= stg.dsts_i[gi*4 +: 4];
                end
            end
            assign w_dsts[gi*4 +: 4] = r_dst;
        end
    endgenerate

    assign stg.icode_o    = r_icode;
    assign stg.ifun_o     = r_ifun;
    assign stg.stat_o     = r_stat;
    assign stg.vals_o     = w_vals;
    assign stg.dsts_o     = w_dsts;
    assign stg.valid_o    = r_valid;
    assign stg.conflict_o = r_conflict;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_bubble_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (stg.bubble_i && r_bubble_cnt != CNT_MAX) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
            end
            if (stg.stall_i && !stg.bubble_i && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign stg.bubble_cnt_o = r_bubble_cnt;
    assign stg.stall_cnt_o  = r_stall_cnt;
`else
    assign stg.bubble_cnt_o = {CNT_W{1'b0}};
    assign stg.stall_cnt_o  = {CNT_W{1'b0}};
`endif

endmodule
